// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush controller.
// Imported by md_busy_timer and hazard_stall_ctrl.
package pipe_ctrl_pkg;

    typedef logic [1:0] t_time_t;

    localparam t_time_t TUSE_NONE       = 2'd3;
    localparam int      MULT_CYCLES_DEF = 5;
    localparam int      DIV_CYCLES_DEF  = 10;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } md_state_t;

endpackage

// File: rtl/md_busy_timer.sv
// Occupancy timer for the multiply/divide unit: loads a down-counter on start and
// raises MD_Busy for exactly MULT_CYCLES / DIV_CYCLES cycles after the start cycle.
//   state | meaning
//   IDLE  | unit free, waiting for E_MDStart
//   BUSY  | operation in flight, cnt = busy cycles remaining including this one
import pipe_ctrl_pkg::*;

module md_busy_timer #(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic Clk,
    input  logic Reset,
    input  logic E_MDStart,
    input  logic E_MDIsDiv,
    output logic MD_Busy,
    output logic MD_Done
);

    localparam int CW = $clog2(DIV_CYCLES + 1);

    md_state_t     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // A start seen while BUSY is ignored; the counter is never reloaded mid-operation.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (E_MDStart) begin
                    state_d = BUSY;
                    cnt_d   = E_MDIsDiv ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
                end
            end
            BUSY: begin
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = IDLE;
                end
            end
        endcase
    end

    assign MD_Busy = (state_q == BUSY);
    assign MD_Done = (state_q == BUSY) && (cnt_q == CW'(1));

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Pipeline stall/flush controller: Tuse/Tnew data-hazard compare plus mult/div occupancy.
// Optional STALL_STATS_EN adds saturating stall counters StallCnt / MDStallCnt.
import pipe_ctrl_pkg::*;

module hazard_stall_ctrl #(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [4:0]  D_Rs,
    input  logic [4:0]  D_Rt,
    input  t_time_t     D_TuseRs,
    input  t_time_t     D_TuseRt,
    input  logic        D_IsMD,
    input  logic        E_RegWrite,
    input  logic [4:0]  E_RegDst,
    input  t_time_t     E_Tnew,
    input  logic        M_RegWrite,
    input  logic [4:0]  M_RegDst,
    input  t_time_t     M_Tnew,
    input  logic        E_MDStart,
    input  logic        E_MDIsDiv,
    output logic        PC_En,
    output logic        FD_En,
    output logic        DE_Flush,
    output logic        MD_Busy,
    output logic        MD_Done
`ifdef STALL_STATS_EN
    ,
    output logic [31:0] StallCnt,
    output logic [31:0] MDStallCnt
`endif
);

    logic stall_rs, stall_rt, stall_md, stall;
    logic md_busy;

    md_busy_timer #(
        .MULT_CYCLES (MULT_CYCLES),
        .DIV_CYCLES  (DIV_CYCLES)
    ) u_md_timer (
        .Clk       (Clk),
        .Reset     (Reset),
        .E_MDStart (E_MDStart),
        .E_MDIsDiv (E_MDIsDiv),
        .MD_Busy   (md_busy),
        .MD_Done   (MD_Done)
    );

    // $0 is hardwired zero and an unused operand (Tuse 3) can never be earlier than Tnew.
    always_comb begin
        stall_rs = (D_Rs != 5'd0) && (D_TuseRs != TUSE_NONE) &&
                   ((E_RegWrite && (E_RegDst == D_Rs) && (D_TuseRs < E_Tnew)) ||
                    (M_RegWrite && (M_RegDst == D_Rs) && (D_TuseRs < M_Tnew)));
        stall_rt = (D_Rt != 5'd0) && (D_TuseRt != TUSE_NONE) &&
                   ((E_RegWrite && (E_RegDst == D_Rt) && (D_TuseRt < E_Tnew)) ||
                    (M_RegWrite && (M_RegDst == D_Rt) && (D_TuseRt < M_Tnew)));
        stall_md = D_IsMD && (E_MDStart || md_busy);
        stall    = stall_rs || stall_rt || stall_md;
    end

    assign PC_En    = ~stall;
    assign FD_En    = ~stall;
    assign DE_Flush = stall;
    assign MD_Busy  = md_busy;

`ifdef STALL_STATS_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] md_stall_cnt_q, md_stall_cnt_d;

    always_comb begin
        stall_cnt_d    = stall_cnt_q;
        md_stall_cnt_d = md_stall_cnt_q;
        if (stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
        if (stall_md && (md_stall_cnt_q != 32'hFFFF_FFFF)) begin
            md_stall_cnt_d = md_stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            stall_cnt_q    <= '0;
            md_stall_cnt_q <= '0;
        end else begin
            stall_cnt_q    <= stall_cnt_d;
            md_stall_cnt_q <= md_stall_cnt_d;
        end
    end

    assign StallCnt   = stall_cnt_q;
    assign MDStallCnt = md_stall_cnt_q;
`endif

endmodule
